// File: rtl/resp_queue.sv
// resp_queue: response FIFO downstream of the output mux, with a per-tag
// outstanding-command scoreboard and sticky overflow / protocol-error flags.
module resp_queue #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic          c_clk,
  input  logic          reset,
  input  logic [0:1]    in_resp,
  input  logic [0:1]    in_tag,
  input  logic [0:31]   in_data,
  input  logic          cmd_valid,
  input  logic [0:1]    cmd_tag,
  input  logic          port_ack,
  output logic [0:1]    port_resp,
  output logic [0:1]    port_tag,
  output logic [0:31]   port_data,
  output logic          almost_full,
  output logic [0:3]    pending_tags,
  output logic          overflow,
  output logic          tag_err,
  output logic [0:CW-1] count
);
  localparam int AW = $clog2(DEPTH);
  logic [0:35]   mem [DEPTH];
  logic [0:35]   head;
  logic [AW-1:0] rd, wr;
  logic [CW-1:0] cnt;
  logic [0:3]    pend, pend_n;
  logic          ovf, terr;
  logic          push, pop, drop, wr_en, cmd_err, rsp_err, has;
  assign push    = in_resp != 2'b00;
  assign pop     = port_ack && cnt != '0;
  assign drop    = push && cnt == CW'(DEPTH) && !pop;
  assign wr_en   = push && !drop;
  assign cmd_err = cmd_valid && pend[cmd_tag] && !(push && in_tag == cmd_tag);
  assign rsp_err = push && !pend[in_tag] && !(cmd_valid && cmd_tag == in_tag);
  // A response retires its tag before a same-cycle issue re-arms it.
  always_comb begin
    pend_n = pend;
    if (push) pend_n[in_tag] = 1'b0;
    if (cmd_valid) pend_n[cmd_tag] = 1'b1;
  end
  always_ff @(posedge c_clk)
    if (wr_en) mem[wr] <= {in_resp, in_tag, in_data};
  always_ff @(posedge c_clk or negedge reset)
    if (!reset) begin
      rd   <= '0;
      wr   <= '0;
      cnt  <= '0;
      pend <= '0;
      ovf  <= 1'b0;
      terr <= 1'b0;
    end else begin
      rd   <= rd + AW'(pop);
      wr   <= wr + AW'(wr_en);
      cnt  <= cnt + CW'(wr_en) - CW'(pop);
      pend <= pend_n;
      ovf  <= ovf | drop;
      terr <= terr | cmd_err | rsp_err;
    end
  assign has          = cnt != '0;
  assign head         = mem[rd];
  assign port_resp    = has ? head[0:1] : '0;
  assign port_tag     = has ? head[2:3] : '0;
  assign port_data    = has ? head[4:35] : '0;
  assign almost_full  = cnt >= CW'(DEPTH - 1);
  assign pending_tags = pend;
  assign overflow     = ovf;
  assign tag_err      = terr;
  assign count        = cnt;
endmodule

// File: tb/tb_resp_queue.sv
// tb_resp_queue: directed and randomized checks of resp_queue against a queue-based model.
module tb_resp_queue;
  logic        clk = 1'b0;
  logic        reset;
  logic [0:1]  in_resp, in_tag, cmd_tag;
  logic [0:31] in_data;
  logic        cmd_valid, port_ack;
  logic [0:1]  port_resp, port_tag;
  logic [0:31] port_data;
  logic        almost_full, overflow, tag_err;
  logic [0:3]  pending_tags;
  logic [0:2]  count;
  int vectors = 0;
  int miscompares = 0;
  logic [35:0] q[$];
  logic [0:3]  pm;
  logic        om, tm;

  resp_queue #(.DEPTH(4), .CW(3)) dut (
    .c_clk(clk), .reset(reset), .in_resp(in_resp), .in_tag(in_tag), .in_data(in_data),
    .cmd_valid(cmd_valid), .cmd_tag(cmd_tag), .port_ack(port_ack),
    .port_resp(port_resp), .port_tag(port_tag), .port_data(port_data),
    .almost_full(almost_full), .pending_tags(pending_tags), .overflow(overflow),
    .tag_err(tag_err), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", nm, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [35:0] h;
    h = (q.size() != 0) ? q[0] : 36'd0;
    chk("port_resp", 64'(port_resp), 64'(h[35:34]));
    chk("port_tag", 64'(port_tag), 64'(h[33:32]));
    chk("port_data", 64'(port_data), 64'(h[31:0]));
    chk("count", 64'(count), 64'(q.size()));
    chk("almost_full", 64'(almost_full), 64'(q.size() >= 3));
    chk("pending_tags", 64'(pending_tags), 64'(pm));
    chk("overflow", 64'(overflow), 64'(om));
    chk("tag_err", 64'(tag_err), 64'(tm));
  endtask

  task automatic model_clear();
    q.delete();
    pm = '0;
    om = 1'b0;
    tm = 1'b0;
  endtask

  task automatic step(input logic [1:0] r, input logic [1:0] t, input logic [31:0] d,
                      input logic cv, input logic [1:0] ct, input logic ack);
    logic push;
    in_resp = r; in_tag = t; in_data = d; cmd_valid = cv; cmd_tag = ct; port_ack = ack;
    @(posedge clk);
    push = r != 2'd0;
    if (cv && pm[ct] && !(push && t == ct)) tm = 1'b1;
    if (push && !pm[t] && !(cv && ct == t)) tm = 1'b1;
    if (push) pm[t] = 1'b0;
    if (cv) pm[ct] = 1'b1;
    if (ack && q.size() != 0) void'(q.pop_front());
    if (push) begin
      if (q.size() == 4) om = 1'b1;
      else q.push_back({r, t, d});
    end
    #1;
    check_all();
  endtask

  task automatic do_reset();
    in_resp = '0; in_tag = '0; in_data = '0; cmd_valid = 1'b0; cmd_tag = '0; port_ack = 1'b0;
    reset = 1'b0;
    @(posedge clk);
    #1;
    model_clear();
    check_all();
    reset = 1'b1;
  endtask

  initial begin
    logic [1:0] tags [4];
    logic [1:0] r;
    tags = '{2'd3, 2'd1, 2'd0, 2'd2};
    // reset state, then a response with no outstanding command
    do_reset();
    step(2'd1, 2'd2, 32'h0000_00FF, 1'b0, 2'd0, 1'b0);
    // issue all tags, respond out of order, drain in FIFO order
    do_reset();
    for (int t = 0; t < 4; t++) step(2'd0, 2'd0, 32'd0, 1'b1, 2'(t), 1'b0);
    for (int i = 0; i < 4; i++) step(2'd1, tags[i], 32'h100 + 32'(i), 1'b0, 2'd0, 1'b0);
    for (int i = 0; i < 4; i++) step(2'd0, 2'd0, 32'd0, 1'b0, 2'd0, 1'b1);
    // fill, push+pop when full, overflow, wrap and drain
    do_reset();
    for (int i = 0; i < 4; i++) step(2'($urandom_range(1, 3)), 2'(i), $urandom, 1'b0, 2'd0, 1'b0);
    step(2'd1, 2'd0, 32'h0000_00A5, 1'b0, 2'd0, 1'b1);
    step(2'd3, 2'd1, 32'h0000_DEAD, 1'b0, 2'd0, 1'b0);
    step(2'd2, 2'd2, 32'h0000_BEEF, 1'b0, 2'd0, 1'b1);
    for (int i = 0; i < 5; i++) step(2'd0, 2'd0, 32'd0, 1'b0, 2'd0, 1'b1);
    // same-cycle issue and response on one tag, then a double issue
    do_reset();
    step(2'd0, 2'd0, 32'd0, 1'b1, 2'd1, 1'b0);
    step(2'd1, 2'd1, 32'h11, 1'b1, 2'd1, 1'b0);
    step(2'd0, 2'd0, 32'd0, 1'b1, 2'd1, 1'b0);
    // ack on empty together with a resp-10 push
    do_reset();
    step(2'd2, 2'd0, 32'd0, 1'b0, 2'd0, 1'b1);
    step(2'd0, 2'd0, 32'd0, 1'b0, 2'd0, 1'b0);
    // asynchronous reset with 3 entries held and overflow set
    do_reset();
    for (int i = 0; i < 5; i++) step(2'd1, 2'(i), 32'h50 + 32'(i), 1'b1, 2'(i), 1'b0);
    step(2'd0, 2'd0, 32'd0, 1'b0, 2'd0, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    model_clear();
    check_all();
    @(posedge clk);
    #1;
    reset = 1'b1;
    step(2'd1, 2'd3, 32'h33, 1'b0, 2'd0, 1'b0);
    // randomized traffic
    for (int k = 0; k < 3; k++) begin
      do_reset();
      for (int n = 0; n < 300; n++) begin
        r = ($urandom_range(0, 9) < 4) ? 2'd0 : 2'($urandom_range(1, 3));
        step(r, 2'($urandom_range(0, 3)), $urandom, 1'($urandom_range(0, 1)),
             2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/resp_queue.md
# resp_queue

Response queue for one CALC-3 port, directly downstream of the output mux. Each cycle with a non-zero mux response (resp, tag, data) is captured into a DEPTH-entry FIFO and held until the requester acknowledges it, so responses are not lost when the requester is slow. A four-entry tag scoreboard tracks outstanding commands per tag. Protocol errors and queue overflow are flagged as sticky bits.

## Interface

- DEPTH, 4, number of queue entries; power of two, 2 to 16.
- CW, 3, count width; must equal log2(DEPTH)+1.

- c_clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low; clears all state immediately when low.
- in_resp  in  [0:1]  response from output mux; non-zero means push.
- in_tag  in  [0:1]  tag of in_resp.
- in_data  in  [0:31]  data of in_resp.
- cmd_valid  in  1  a command is issued this cycle.
- cmd_tag  in  [0:1]  tag of the issued command.
- port_ack  in  1  requester consumes the head entry this cycle.
- port_resp  out  [0:1]  head entry resp; 00 when empty.
- port_tag  out  [0:1]  head entry tag; 00 when empty.
- port_data  out  [0:31]  head entry data; 0 when empty.
- almost_full  out  1  count >= DEPTH-1; upstream stalls command issue.
- pending_tags  out  [0:3]  bit i set means tag i is outstanding.
- overflow  out  1  sticky; a push was dropped.
- tag_err  out  1  sticky; a scoreboard protocol violation occurred.
- count  out  [0:CW-1]  entries held, 0 to DEPTH.

## Operation

- Storage: DEPTH entries of 36 bits {resp, tag, data}, with a rd pointer and a wr pointer, each log2(DEPTH) bits and wrapping modulo DEPTH.
- Push: in_resp != 00.
  - Write the entry at wr and advance wr.
  - If the queue is full and no pop occurs in the same cycle, drop the entry, set overflow, and leave wr and count unchanged.
- Pop: port_ack = 1 and count != 0. Advance rd. port_ack while empty is ignored.
- Simultaneous push and pop:
  - count unchanged; both pointers advance.
  - Allowed when full: the pop frees a slot, no overflow.
  - Allowed when empty: the pop is ignored, so this is a plain push.
- Outputs are combinational from the head entry at rd, gated to zero when count = 0.
- All resp codes are queued verbatim, including 10 (invalid op) and 11. Data is not interpreted.
- Scoreboard, pending[0:3]:
  - cmd_valid sets pending[cmd_tag].
  - A push clears pending[in_tag]; a dropped push still clears it.
- tag_err is set when either of these occurs:
  - cmd_valid with pending[cmd_tag] already set, unless the same cycle's push clears that tag.
  - A push with pending[in_tag] clear, unless the same cycle's cmd_valid sets that tag.
- Same-tag issue and response in one cycle: the response retires the old command and the issue sets pending again. Final state: pending = 1, no error.
- overflow and tag_err clear only on reset.

## Timing

- Reset values (reset low): count = 0, pointers = 0, pending_tags = 0000, overflow = 0, tag_err = 0, port_resp = 00, port_tag = 00, port_data = 0, almost_full = 0.
- Reset mid-operation discards all entries at once; outputs go to their reset values asynchronously.
- Push latency: an entry pushed at edge N is visible on port_* after edge N when the queue was empty. Otherwise it appears after all older entries have popped.
- Pop: with port_ack high at edge N, the next entry (or zeros) appears after edge N.
- There is no bypass: in_* never reaches port_* in the same cycle.
- almost_full, count and pending_tags are registered-state derived and change only after an edge.
- Sticky flags assert after the offending edge.
- Throughput: one push and one pop per cycle, sustained.

## Test plan

- Reset, then push resp 01, tag 2, data 0x0000_00FF with no ack. Required: port shows 01/2/0x000000FF after one edge; count = 1; pending[2] clears if it was set, else tag_err = 1.
- Issue tags 0–3, then push 4 responses (tags 3, 1, 0, 2), then ack 4 times. Required: FIFO order 3, 1, 0, 2 on the port; pending 1111 → 0000; tag_err = 0; count = 0; port returns to zeros.
- Fill to DEPTH = 4 (almost_full rises when count = 3), then push a 5th with no ack. Required: overflow = 1, count = 4, head unchanged. Repeat the full push with port_ack = 1: overflow stays at its prior value, count stays 4, entries wrap correctly.
- Same-cycle cmd_valid tag 1 and push tag 1 while pending[1] = 1. Required: pending[1] = 1, tag_err = 0. Then cmd_valid tag 1 alone. Required: tag_err = 1.
- port_ack on an empty queue, together with a push of resp 10, tag 0. Required: count = 1; port shows 10/0/0x00000000 next cycle.
- Assert reset asynchronously mid-cycle with 3 entries held and overflow set. Required: all outputs are zero immediately. After release, a new push behaves as from an empty queue.
